// File: rtl/demux2_pkg.sv
// Shared encodings for the two-way byte-stream demultiplexer.
package demux2_pkg;

    // One bit is enough: either between packets or inside one.
    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_PKT  = 1'b1
    } state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux2_stream_if.sv
// Bundle of the demux stream signals: one upstream port and two lanes.
// Handshake: a beat moves on a rising edge where its valid and ready are both
// high; valid never waits on ready, and data/last are held while valid is high.
interface demux2_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  select;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data0;
    logic                  last0;
    logic                  valid0;
    logic                  ready0;
    logic [DATA_WIDTH-1:0] data1;
    logic                  last1;
    logic                  valid1;
    logic                  ready1;
    logic                  busy;

    // Producer/consumer side surrounding the demux.
    modport master (
        output data, last, select, valid, ready0, ready1,
        input  ready, data0, last0, valid0, data1, last1, valid1, busy
    );

    // The demux itself.
    modport slave (
        input  data, last, select, valid, ready0, ready1,
        output ready, data0, last0, valid0, data1, last1, valid1, busy
    );
endinterface

// File: rtl/demux2_fifo.sv
// Small synchronous FIFO used as the per-lane buffer of demux2_stream.
module demux2_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even when a pop happens the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the lane head reads zero afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/demux2_stream.sv
// Two-way packet demultiplexer: whole packets are steered to lane 0 or lane 1
// by the select bit on their first beat, each lane buffered by its own FIFO.
module demux2_stream
    import demux2_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic [DATA_WIDTH-1:0] iDATA,
    input  logic                  iLAST,
    input  logic                  iSELECT,
    input  logic                  iVALID,
    output logic                  oREADY,
    output logic [DATA_WIDTH-1:0] oDATA0,
    output logic                  oLAST0,
    output logic                  oVALID0,
    input  logic                  iREADY0,
    output logic [DATA_WIDTH-1:0] oDATA1,
    output logic                  oLAST1,
    output logic                  oVALID1,
    input  logic                  iREADY1,
    output logic                  oBUSY
);
    localparam int W  = DATA_WIDTH + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          target;
    logic          accept;
    logic          push0, push1;
    logic          pop0, pop1;
    logic          full0, full1;
    logic          empty0, empty1;
    logic [CW-1:0] count0, count1;
    logic [W-1:0]  head0, head1;

    // Lane choice and readiness: only FIFO occupancy gates oREADY, never iREADYx.
    always_comb begin
        target = (state_q == STATE_PKT) ? sel_q : iSELECT;
        oREADY = inRESET && !((target == LANE1) ? full1 : full0);
        accept = iVALID && oREADY;
        push0  = accept && (target == LANE0);
        push1  = accept && (target == LANE1);
        pop0   = iREADY0 && !empty0;
        pop1   = iREADY1 && !empty1;
    end

    // Packet FSM next-state: the lane is latched on a non-final first beat.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            STATE_IDLE: begin
                if (accept && !iLAST) begin
                    state_d = STATE_PKT;
                    sel_d   = iSELECT;
                end
            end
            STATE_PKT: begin
                if (accept && iLAST) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // FSM and lane-select registers; reset discards any partial packet.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= STATE_IDLE;
            sel_q   <= LANE0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    demux2_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo0 (
        .clk_i   (iCLOCK),
        .rst_ni  (inRESET),
        .push_i  (push0),
        .wdata_i ({iDATA, iLAST}),
        .pop_i   (pop0),
        .rdata_o (head0),
        .full_o  (full0),
        .empty_o (empty0),
        .count_o (count0)
    );

    demux2_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo1 (
        .clk_i   (iCLOCK),
        .rst_ni  (inRESET),
        .push_i  (push1),
        .wdata_i ({iDATA, iLAST}),
        .pop_i   (pop1),
        .rdata_o (head1),
        .full_o  (full1),
        .empty_o (empty1),
        .count_o (count1)
    );

    assign oDATA0  = head0[W-1:1];
    assign oLAST0  = head0[0];
    assign oVALID0 = (count0 != '0);
    assign oDATA1  = head1[W-1:1];
    assign oLAST1  = head1[0];
    assign oVALID1 = (count1 != '0);
    assign oBUSY   = (state_q == STATE_PKT);
endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream: vector table plus hand-written corner cases.
module tb_demux2_stream;
  logic clk;
  logic rst_n;
  int checks;
  int errors;

  demux2_stream_if #(.DATA_WIDTH(8)) bus ();

  demux2_stream #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .iCLOCK  (clk),
    .inRESET (rst_n),
    .iDATA   (bus.data),
    .iLAST   (bus.last),
    .iSELECT (bus.select),
    .iVALID  (bus.valid),
    .oREADY  (bus.ready),
    .oDATA0  (bus.data0),
    .oLAST0  (bus.last0),
    .oVALID0 (bus.valid0),
    .iREADY0 (bus.ready0),
    .oDATA1  (bus.data1),
    .oLAST1  (bus.last1),
    .oVALID1 (bus.valid1),
    .iREADY1 (bus.ready1),
    .oBUSY   (bus.busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       s;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_l0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic       e_l1;
    logic       e_busy;
  } vec_t;

  vec_t vecs [18];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s,
                       input logic r0, input logic r1);
    bus.valid  = v;
    bus.data   = d;
    bus.last   = l;
    bus.select = s;
    bus.ready0 = r0;
    bus.ready1 = r1;
  endtask

  // Lane checks: data/last only matter while the lane head is valid.
  task automatic chk_lanes(input string tag, input logic v0, input logic [7:0] d0, input logic l0,
                           input logic v1, input logic [7:0] d1, input logic l1);
    chk({tag, " valid0"}, 32'(bus.valid0), 32'(v0));
    if (v0) begin
      chk({tag, " data0"}, 32'(bus.data0), 32'(d0));
      chk({tag, " last0"}, 32'(bus.last0), 32'(l0));
    end
    chk({tag, " valid1"}, 32'(bus.valid1), 32'(v1));
    if (v1) begin
      chk({tag, " data1"}, 32'(bus.data1), 32'(d1));
      chk({tag, " last1"}, 32'(bus.last1), 32'(l1));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);

    // Rows are inputs for one cycle and the outputs seen before that cycle's edge.
    //            v  d      l  s  r0 r1  rdy v0 d0    l0 v1 d1     l1 busy
    // 3-beat packet to lane 1, select toggled after the first beat
    vecs[0]  = '{1, 8'h11, 0, 1, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 8'h22, 0, 0, 1, 1,  1, 0, 8'h00, 0, 1, 8'h11, 0, 1};
    vecs[2]  = '{1, 8'h33, 1, 0, 1, 1,  1, 0, 8'h00, 0, 1, 8'h22, 0, 1};
    vecs[3]  = '{0, 8'h00, 0, 0, 1, 1,  1, 0, 8'h00, 0, 1, 8'h33, 1, 0};
    vecs[4]  = '{0, 8'h00, 0, 0, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    // back-to-back single-beat packets
    vecs[5]  = '{1, 8'hA0, 1, 0, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    vecs[6]  = '{1, 8'hB1, 1, 1, 1, 1,  1, 1, 8'hA0, 1, 0, 8'h00, 0, 0};
    vecs[7]  = '{1, 8'hC2, 1, 0, 1, 1,  1, 0, 8'h00, 0, 1, 8'hB1, 1, 0};
    vecs[8]  = '{0, 8'h00, 0, 0, 1, 1,  1, 1, 8'hC2, 1, 0, 8'h00, 0, 0};
    vecs[9]  = '{0, 8'h00, 0, 0, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    // 6-beat packet into stalled lane 1 fills it, one-cycle ready admits one more
    vecs[10] = '{1, 8'h60, 0, 1, 1, 0,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    vecs[11] = '{1, 8'h61, 0, 0, 1, 0,  1, 0, 8'h00, 0, 1, 8'h60, 0, 1};
    vecs[12] = '{1, 8'h62, 0, 0, 1, 0,  1, 0, 8'h00, 0, 1, 8'h60, 0, 1};
    vecs[13] = '{1, 8'h63, 0, 0, 1, 0,  1, 0, 8'h00, 0, 1, 8'h60, 0, 1};
    vecs[14] = '{1, 8'h64, 0, 0, 1, 0,  0, 0, 8'h00, 0, 1, 8'h60, 0, 1};
    vecs[15] = '{1, 8'h64, 0, 0, 1, 1,  0, 0, 8'h00, 0, 1, 8'h60, 0, 1};
    vecs[16] = '{1, 8'h64, 0, 0, 1, 0,  1, 0, 8'h00, 0, 1, 8'h61, 0, 1};
    vecs[17] = '{1, 8'h65, 1, 0, 1, 0,  0, 0, 8'h00, 0, 1, 8'h61, 0, 1};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst ready", 32'(bus.ready), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst valid0", 32'(bus.valid0), 32'd0);
    chk("rst valid1", 32'(bus.valid1), 32'd0);
    chk("rst data0", 32'(bus.data0), 32'd0);
    chk("rst data1", 32'(bus.data1), 32'd0);
    chk("rst last0", 32'(bus.last0), 32'd0);
    chk("rst last1", 32'(bus.last1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 8'h00, 0, 0, 1, 1);
    #1;
    chk("post-rst ready", 32'(bus.ready), 32'd1);
    chk_lanes("post-rst", 0, 8'h00, 0, 0, 8'h00, 0);

    // table-driven vectors
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].s, vecs[i].r0, vecs[i].r1);
      #1;
      chk($sformatf("vec%0d ready", i), 32'(bus.ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      chk_lanes($sformatf("vec%0d", i), vecs[i].e_v0, vecs[i].e_d0, vecs[i].e_l0,
                vecs[i].e_v1, vecs[i].e_d1, vecs[i].e_l1);
    end

    // lane 1 full: one more pop lets the final beat in, then lane 0 runs at full rate
    @(negedge clk);
    drive(1, 8'h65, 1, 0, 1, 1);
    #1;
    chk("full ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    drive(1, 8'h65, 1, 0, 1, 0);
    #1;
    chk("last admit ready", 32'(bus.ready), 32'd1);
    chk("last admit busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    drive(1, 8'h70, 0, 0, 1, 0);
    #1;
    chk("l0 b0 ready", 32'(bus.ready), 32'd1);
    chk("l0 b0 busy", 32'(bus.busy), 32'd0);
    chk_lanes("l0 b0", 0, 8'h00, 0, 1, 8'h62, 0);
    @(negedge clk);
    drive(1, 8'h71, 0, 1, 1, 0);
    #1;
    chk("l0 b1 ready", 32'(bus.ready), 32'd1);
    chk("l0 b1 busy", 32'(bus.busy), 32'd1);
    chk_lanes("l0 b1", 1, 8'h70, 0, 1, 8'h62, 0);
    @(negedge clk);
    drive(1, 8'h72, 1, 1, 1, 0);
    #1;
    chk("l0 b2 ready", 32'(bus.ready), 32'd1);
    chk_lanes("l0 b2", 1, 8'h71, 0, 1, 8'h62, 0);
    @(negedge clk);
    drive(0, 8'h00, 0, 0, 1, 0);
    #1;
    chk("l0 b3 busy", 32'(bus.busy), 32'd0);
    chk_lanes("l0 b3", 1, 8'h72, 1, 1, 8'h62, 0);
    @(negedge clk);
    #1;
    chk("l0 drained", 32'(bus.valid0), 32'd0);

    // drain lane 1 through the scoreboard: no loss or duplication
    exp_q = '{8'h62, 8'h63, 8'h64, 8'h65};
    bus.ready1 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      #1;
      chk($sformatf("drain%0d valid1", n), 32'(bus.valid1), 32'd1);
      chk($sformatf("drain%0d data1", n), 32'(bus.data1), 32'(e));
      chk($sformatf("drain%0d last1", n), 32'(bus.last1), (n == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    #1;
    chk("drain empty valid1", 32'(bus.valid1), 32'd0);

    // reset in the middle of a 4-beat packet to stalled lane 1
    @(negedge clk);
    drive(1, 8'h90, 0, 1, 1, 0);
    @(negedge clk);
    drive(1, 8'h91, 0, 0, 1, 0);
    #1;
    chk("mid busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    drive(0, 8'h00, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst ready", 32'(bus.ready), 32'd0);
    chk("midrst valid0", 32'(bus.valid0), 32'd0);
    chk("midrst valid1", 32'(bus.valid1), 32'd0);
    chk("midrst data1", 32'(bus.data1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 8'h80, 0, 0, 1, 0);
    #1;
    chk("fresh b0 ready", 32'(bus.ready), 32'd1);
    chk_lanes("fresh b0", 0, 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk);
    drive(1, 8'h81, 1, 1, 1, 0);
    #1;
    chk("fresh b1 busy", 32'(bus.busy), 32'd1);
    chk_lanes("fresh b1", 1, 8'h80, 0, 0, 8'h00, 0);
    @(negedge clk);
    drive(0, 8'h00, 0, 0, 1, 0);
    #1;
    chk("fresh end busy", 32'(bus.busy), 32'd0);
    chk_lanes("fresh end", 1, 8'h81, 1, 0, 8'h00, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
